uart_rx: RTL and testbench

- UART 8N1 receive path; the receive-direction counterpart of the register-driven transmit path.
- Consumes rx enable, CRC enable and clock divider from the UART configuration registers. Deserialises the asynchronous uart_rx_i line.
- Presents bytes to the register block's RX_DATA read path, with frame-error, overrun and running CRC-8 check status.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_crc8.sv | 31 +++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, CRC-8 constants and the
// byte-wise CRC-8 update used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam logic [7:0] UART_CRC_POLY = 8'h07;
  localparam logic [7:0] UART_CRC_INIT = 8'h00;

  // MSB-first CRC-8 over one byte: XOR the byte in, then shift out 8 bits.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly = UART_CRC_POLY);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ poly;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_crc8.sv
// Running CRC-8 accumulator. A clear has priority over a fold in the same
// cycle; seen records whether any byte has been folded since the last clear.
module uart_crc8
  import uart_pkg::*;
#(
  parameter logic [7:0] POLY = UART_CRC_POLY
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] data,
  input  logic       valid,
  output logic [7:0] crc,
  output logic       seen
);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      crc  <= UART_CRC_INIT;
      seen <= 1'b0;
    end else if (clr) begin
      crc  <= UART_CRC_INIT;
      seen <= 1'b0;
    end else if (en && valid) begin
      crc  <= crc8_byte(crc, data, POLY);
      seen <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises the serial line, deserialises LSB-first
// frames at a per-frame latched divider, and feeds accepted bytes to a CRC-8.
module uart_rx
  import uart_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CRC_POLY    = UART_CRC_POLY
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        rx_en_i,
  input  logic        crc_en_i,
  input  logic [15:0] clock_divider_i,
  input  logic        uart_rx_i,
  input  logic        rx_rd_i,
  input  logic        crc_clr_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic [7:0]  crc_value_o,
  output logic        crc_ok_o,
  output logic        busy_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  uart_rx_state_t state;
  logic [15:0]    cnt;
  logic [15:0]    n_lat;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;

  logic [15:0] half_m1;
  logic [15:0] n_m1;
  logic        accept;
  logic        crc_seen;

  // Idle-high reset so a cold start never looks like a start bit.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
  end

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign half_m1 = (n_lat >> 1) - 16'd1;
  assign n_m1    = n_lat - 16'd1;
  assign accept  = rx_en_i && (state == STOP) && (cnt == n_m1) && rxs;

  // rx_valid_o is a level: set by an accepted byte, cleared by rx_rd_i; a
  // read in the same cycle as an accept keeps it set without an overrun.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      n_lat       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      if (accept) begin
        rx_data_o  <= shift;
        rx_valid_o <= 1'b1;
        overrun_o  <= rx_valid_o && !rx_rd_i;
      end else if (rx_rd_i) begin
        rx_valid_o <= 1'b0;
      end

      if (!rx_en_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if ((clock_divider_i >= 16'd2) && !rxs) begin
              n_lat <= clock_divider_i;
              cnt   <= '0;
              state <= START;
            end
          end
          START: begin
            if (cnt == half_m1) begin
              if (!rxs) begin
                cnt     <= '0;
                bit_idx <= '0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DATA: begin
            if (cnt == n_m1) begin
              shift[bit_idx] <= rxs;
              cnt            <= '0;
              if (bit_idx == 3'd7) state <= STOP;
              else                 bit_idx <= bit_idx + 3'd1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          STOP: begin
            if (cnt == n_m1) begin
              state <= IDLE;
              if (!rxs) frame_err_o <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  uart_crc8 #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clk  (clk),
    .rst_i(rst_i),
    .en   (crc_en_i),
    .clr  (crc_clr_i),
    .data (shift),
    .valid(accept),
    .crc  (crc_value_o),
    .seen (crc_seen)
  );

  assign crc_ok_o = crc_en_i && crc_seen && (crc_value_o == 8'h00);
  assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, glitch rejection, frame error,
// overrun, CRC-8, enable abort, mid-frame reset and divider handling.
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        rx_en;
  logic        crc_en;
  logic [15:0] div;
  logic        line;
  logic        rd;
  logic        clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic [7:0]  crc_value;
  logic        crc_ok;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0       = 0;
  int rise_cyc = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int busy_cnt = 0;
  logic vprev  = 1'b0;
  int fe0, ov0, b0;

  logic [7:0] exp_q[$];

  uart_rx #(.SYNC_STAGES(2), .CRC_POLY(8'h07)) dut (
    .clk            (clk),
    .rst_i          (rst),
    .rx_en_i        (rx_en),
    .crc_en_i       (crc_en),
    .clock_divider_i(div),
    .uart_rx_i      (line),
    .rx_rd_i        (rd),
    .crc_clr_i      (clr),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .frame_err_o    (frame_err),
    .overrun_o      (overrun),
    .crc_value_o    (crc_value),
    .crc_ok_o       (crc_ok),
    .busy_o         (busy)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // pulse and level monitors, sampled on the inactive edge
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
    if (rx_valid && !vprev) rise_cyc = cyc;
    vprev = rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_data(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check_eq(tag, {24'd0, rx_data}, {24'd0, e});
  endtask

  // Start bit begins just after edge E0 (cycle stamp saved in c0).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int n);
    @(posedge clk);
    #1 line = 1'b0;
    c0 = cyc;
    repeat (n) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 line = b[i];
      repeat (n) @(posedge clk);
    end
    #1 line = stop;
    repeat (n) @(posedge clk);
    #1 line = 1'b1;
    repeat (2 * n) @(posedge clk);
  endtask

  task automatic rd_pulse();
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b1; crc_en = 1'b0; div = 16'd16;
    line = 1'b1; rd = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", {24'd0, rx_data}, 32'h0);
    check_eq("rst_valid", {31'd0, rx_valid}, 32'h0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'h0);
    check_eq("rst_ovr", {31'd0, overrun}, 32'h0);
    check_eq("rst_crc", {24'd0, crc_value}, 32'h0);
    check_eq("rst_crc_ok", {31'd0, crc_ok}, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // good frame at N=16: stop sample at E0 + 3 + 8 + 144 = E155
    fe0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 16);
    check_eq("a5_latency", rise_cyc - c0, 155);
    expect_data("a5_data");
    check_eq("a5_valid", {31'd0, rx_valid}, 32'h1);
    check_eq("a5_ferr", fe_cnt - fe0, 0);
    rd_pulse();
    check_eq("rd_clears_valid", {31'd0, rx_valid}, 32'h0);
    check_eq("rd_data_hold", {24'd0, rx_data}, 32'hA5);

    // 4-cycle glitch: START from E3 to the E11 sample, 8 busy cycles
    b0 = busy_cnt;
    @(posedge clk);
    #1 line = 1'b0;
    repeat (4) @(posedge clk);
    #1 line = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("glitch_busy_cycles", busy_cnt - b0, 8);
    check_eq("glitch_valid", {31'd0, rx_valid}, 32'h0);
    check_eq("glitch_ferr", fe_cnt - fe0, 0);

    // bad stop bit
    send_frame(8'h3C, 1'b0, 16);
    check_eq("ferr_pulse", fe_cnt - fe0, 1);
    check_eq("ferr_valid", {31'd0, rx_valid}, 32'h0);
    check_eq("ferr_data_hold", {24'd0, rx_data}, 32'hA5);

    // overrun, then read coincident with the accept edge E155
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 16);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 16);
    check_eq("ovr_pulse", ov_cnt - ov0, 1);
    expect_data("ovr_data");
    check_eq("ovr_valid", {31'd0, rx_valid}, 32'h1);
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1, 16);
      begin
        repeat (155) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    check_eq("rd_accept_no_ovr", ov_cnt - ov0, 1);
    expect_data("rd_accept_data");
    check_eq("rd_accept_valid", {31'd0, rx_valid}, 32'h1);
    rd_pulse();

    // CRC: nothing folded while disabled
    check_eq("crc_frozen_off", {24'd0, crc_value}, 32'h0);
    crc_en = 1'b1;
    clr_pulse();
    send_frame(8'h01, 1'b1, 16);
    check_eq("crc_01", {24'd0, crc_value}, 32'h07);
    check_eq("crc_ok_01", {31'd0, crc_ok}, 32'h0);
    rd_pulse();
    send_frame(8'h07, 1'b1, 16);
    check_eq("crc_07", {24'd0, crc_value}, 32'h00);
    check_eq("crc_ok_07", {31'd0, crc_ok}, 32'h1);
    rd_pulse();
    clr_pulse();
    check_eq("crc_ok_clr", {31'd0, crc_ok}, 32'h0);
    crc_en = 1'b0;
    send_frame(8'h55, 1'b1, 16);
    check_eq("crc_en_off_freeze", {24'd0, crc_value}, 32'h00);
    rd_pulse();

    // rx_en dropped during data bit 3 (E59..E75)
    crc_en = 1'b1;
    send_frame(8'h01, 1'b1, 16);
    check_eq("abort_pre_crc", {24'd0, crc_value}, 32'h07);
    rd_pulse();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'hF0, 1'b1, 16);
      begin
        repeat (66) @(posedge clk);
        #1;
        check_eq("abort_busy_before", {31'd0, busy}, 32'h1);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_busy_after", {31'd0, busy}, 32'h0);
      end
    join
    rx_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_valid", {31'd0, rx_valid}, 32'h0);
    check_eq("abort_crc", {24'd0, crc_value}, 32'h07);
    check_eq("abort_ferr", fe_cnt - fe0, 0);
    check_eq("abort_ovr", ov_cnt - ov0, 0);

    // asynchronous reset mid-frame
    send_frame(8'h99, 1'b1, 16);
    check_eq("pre_rst_valid", {31'd0, rx_valid}, 32'h1);
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        repeat (61) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_data", {24'd0, rx_data}, 32'h0);
        check_eq("mid_rst_valid", {31'd0, rx_valid}, 32'h0);
        check_eq("mid_rst_crc", {24'd0, crc_value}, 32'h0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'h0);
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 16);
    expect_data("post_rst_data");
    check_eq("post_rst_valid", {31'd0, rx_valid}, 32'h1);
    check_eq("post_rst_crc", {24'd0, crc_value}, 32'h81);
    rd_pulse();

    // divider of 0 ignores the line
    div = 16'd0;
    b0 = busy_cnt;
    @(posedge clk);
    #1 line = 1'b0;
    repeat (40) @(posedge clk);
    #1 line = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("div0_busy", busy_cnt - b0, 0);
    check_eq("div0_valid", {31'd0, rx_valid}, 32'h0);

    // divider change mid-frame applies to the next frame only
    div = 16'd16;
    exp_q.push_back(8'h4B);
    fork
      send_frame(8'h4B, 1'b1, 16);
      begin
        repeat (80) @(posedge clk);
        #1 div = 16'd8;
      end
    join
    expect_data("div_mid_data");
    check_eq("div_mid_valid", {31'd0, rx_valid}, 32'h1);
    rd_pulse();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 8);
    check_eq("n8_latency", rise_cyc - c0, 79);
    expect_data("n8_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
